// File: rtl/router_pkg.sv
// Shared types and constants for the mesh router output-port logic.
package router_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam int unsigned MAXFLITS_DEFAULT = 16;

  // Index width that stays at least one bit wide for single-requester ports.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping from NREQ-1 back to 0.
module rr_pick
  import router_pkg::*;
#(
  parameter  int unsigned NREQ = 3,
  localparam int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o
);

  always_comb begin
    logic          found;
    int unsigned   s;
    logic [IW-1:0] j;
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    s        = 0;
    j        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      s = 32'(ptr_i) + k;
      j = IW'(s % NREQ);
      if (!found && req_i[j]) begin
        found       = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = j;
      end
    end
  end

endmodule

// File: rtl/router_outport_arbiter.sv
// Wormhole round-robin arbiter for one router output port: locks the port to
// one input from header to tail and strobes xfer for every flit moved.
module router_outport_arbiter
  import router_pkg::*;
#(
  parameter  int unsigned NREQ     = 3,
  parameter  int unsigned MAXFLITS = MAXFLITS_DEFAULT,
  localparam int unsigned IW       = idx_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] valid,
  input  logic [NREQ-1:0] tail,
  input  logic            ready,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            xfer,
  output logic            busy,
  output logic            len_err
);

  // One extra count value so the counter can sit at MAXFLITS+1 even when
  // MAXFLITS+1 is a power of two.
  localparam int unsigned CW       = $clog2(MAXFLITS + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAXFLITS);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAXFLITS + 1);
  localparam logic [IW-1:0] LAST    = IW'(NREQ - 1);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            xfer_c;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i    (req & valid),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    xfer_c  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|pick_oh) begin
          state_d = ARB_LOCK;
          grant_d = pick_oh;
          idx_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      ARB_LOCK: begin
        xfer_c = valid[idx_q] & ready;
        if (xfer_c) begin
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_MAX && !tail[idx_q]) err_d = 1'b1;
          if (tail[idx_q]) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            ptr_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign xfer      = xfer_c;
  assign busy      = (state_q == ARB_LOCK);
  assign len_err   = err_q;

endmodule

// File: tb/tb_router_outport_arbiter.sv
// Randomised bench for router_outport_arbiter against a packet-level
// ownership model of the output port.
module tb_router_outport_arbiter;

  localparam int NREQ = 3;
  localparam int MAXF = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req, valid, tail;
  logic            ready;
  logic [NREQ-1:0] grant;
  logic [1:0]      grant_idx;
  logic            xfer, busy, len_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Upstream sources: current packet length (0 = none) and flits already sent.
  int plen[NREQ];
  int pos[NREQ];
  int p_valid, p_ready, p_req, p_new, minlen, maxlen;

  // Port model: which input owns the port, where the next search starts,
  // last winner, flits moved in the current packet, sticky length error.
  int m_owner, m_ptr, m_last, m_cnt;
  bit m_err;
  bit prev_busy;
  int dut_winners[$];

  router_outport_arbiter #(.NREQ(NREQ), .MAXFLITS(MAXF)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .valid     (valid),
    .tail      (tail),
    .ready     (ready),
    .grant     (grant),
    .grant_idx (grant_idx),
    .xfer      (xfer),
    .busy      (busy),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_last    = 0;
    m_cnt     = 0;
    m_err     = 1'b0;
    prev_busy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      plen[i] = 0;
      pos[i]  = 0;
    end
    req   = '0;
    valid = '0;
    tail  = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (plen[i] == 0 && $urandom_range(0, 99) < p_new) begin
        plen[i] = $urandom_range(minlen, maxlen);
        pos[i]  = 0;
      end
      valid[i] = (plen[i] != 0) && ($urandom_range(0, 99) < p_valid);
      tail[i]  = (plen[i] != 0) && (pos[i] == plen[i] - 1);
      req[i]   = (plen[i] != 0) && (pos[i] == 0) && ($urandom_range(0, 99) < p_req);
    end
    ready = ($urandom_range(0, 99) < p_ready);
  endtask

  task automatic cycle();
    logic ex;
    int   o;
    bit   found;
    drive();
    #1;
    ex = (m_owner >= 0) && valid[m_owner] && ready;
    check_val("xfer", {31'b0, xfer}, {31'b0, ex});
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        o = (m_ptr + k) % NREQ;
        if (!found && req[o] && valid[o]) begin
          found   = 1'b1;
          m_owner = o;
          m_last  = o;
          m_cnt   = 0;
        end
      end
    end else if (ex) begin
      o = m_owner;
      if (m_cnt >= MAXF && !tail[o]) m_err = 1'b1;
      m_cnt++;
      pos[o]++;
      if (tail[o]) begin
        plen[o] = 0;
        m_ptr   = (o + 1) % NREQ;
        m_owner = -1;
      end
    end
    @(posedge clk);
    #1;
    check_val("grant", {29'b0, grant}, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check_val("grant_idx", {30'b0, grant_idx}, m_last);
    check_val("busy", {31'b0, busy}, {31'b0, (m_owner >= 0)});
    check_val("len_err", {31'b0, len_err}, {31'b0, m_err});
    if (busy && !prev_busy) dut_winners.push_back(int'(grant_idx));
    prev_busy = busy;
  endtask

  task automatic async_reset_check();
    #2;
    rst = 1'b0;
    #1;
    check_val("rst_grant", {29'b0, grant}, 32'd0);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_len_err", {31'b0, len_err}, 32'd0);
    check_val("rst_xfer", {31'b0, xfer}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int exp_order[4];
    exp_order = '{0, 1, 2, 0};
    model_reset();
    rst   = 1'b0;
    req   = '1;
    valid = '1;
    ready = 1'b1;
    #3;
    check_val("reset_grant", {29'b0, grant}, 32'd0);
    check_val("reset_xfer", {31'b0, xfer}, 32'd0);
    check_val("reset_len_err", {31'b0, len_err}, 32'd0);
    check_val("reset_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check_val("reset_grant_held", {29'b0, grant}, 32'd0);
    check_val("reset_grant_idx", {30'b0, grant_idx}, 32'd0);
    rst = 1'b1;

    // Every input always has a 2-flit packet ready: strict rotation.
    p_new = 100; minlen = 2; maxlen = 2;
    p_valid = 100; p_ready = 100; p_req = 100;
    dut_winners.delete();
    for (int c = 0; c < 12; c++) cycle();
    check_val("rr_count", dut_winners.size() >= 4, 32'd1);
    for (int w = 0; w < 4; w++)
      if (w < dut_winners.size()) check_val("rr_order", dut_winners[w], exp_order[w]);

    // Random traffic with bubbles, backpressure and withdrawn requests.
    p_new = 40; minlen = 1; maxlen = MAXF;
    p_valid = 75; p_ready = 70; p_req = 85;
    for (int c = 0; c < 600; c++) cycle();

    // Over-length packet on input 0 only.
    async_reset_check();
    p_new = 0; p_valid = 100; p_ready = 100; p_req = 100;
    plen[0] = 6;
    pos[0]  = 0;
    for (int c = 0; c < 10; c++) cycle();
    check_val("len_err_sticky", {31'b0, len_err}, 32'd1);

    // Reset in the middle of a long packet on input 1.
    plen[1] = 6;
    pos[1]  = 0;
    for (int c = 0; c < 4; c++) cycle();
    async_reset_check();
    p_new = 40; minlen = 1; maxlen = MAXF;
    p_valid = 80; p_ready = 80; p_req = 90;
    for (int c = 0; c < 100; c++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
